pll_reset_sequencer: RTL and testbench

// - Drives the reset of the on-board PLL (10 MHz ref -> 2/10/25 MHz) and consumes its async 'locked'.
// - Sequences power-up: holds PLL reset, waits for lock with timeout, qualifies lock stability,

---
 rtl/pll_reset_sequencer_pkg.sv | 28 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 28 ++
 rtl/pll_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// default timing for a 10 MHz reference, and a small sizing helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_QUALIFY   = 2'd2,
    ST_RUN       = 2'd3
  } pll_seq_state_e;

  // Defaults for the 10 MHz reference clock.
  localparam int unsigned DEF_HOLD_CYCLES    = 100;    // 10 us
  localparam int unsigned DEF_LOCK_TIMEOUT   = 10000;  // 1 ms
  localparam int unsigned DEF_QUALIFY_CYCLES = 1000;   // 100 us
  localparam int unsigned DEF_LOSS_FILTER    = 4;
  localparam int unsigned DEF_CNT_W          = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared to 0 on reset.
// Latency: 2 clk cycles. Backpressure: none (free-running sampler).
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds PLL in reset, waits for lock with timeout, qualifies
// lock, releases system reset, and re-sequences on loss of lock or sw strobe.
// Latency: outputs registered from next-state; locked input seen 2 cycles late. Backpressure: none.
// Ports: clk/rst_n; pll_locked_i (async), sw_reset_i (strobe); pll_rst_o, sys_rst_n_o,
//        ready_o, timeout_o (sticky), retry_cnt_o / loss_cnt_o (saturating).
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned QUALIFY_CYCLES = DEF_QUALIFY_CYCLES,
  parameter int unsigned LOSS_FILTER    = DEF_LOSS_FILTER,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked_i,
  input  logic             sw_reset_i,
  output logic             pll_rst_o,
  output logic             sys_rst_n_o,
  output logic             ready_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned TMR_MAX = max3(HOLD_CYCLES, LOCK_TIMEOUT, QUALIFY_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned FLT_W   = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that saw lock is the first of the qualifying run,
  // so QUALIFY itself only needs QUALIFY_CYCLES-1 more locked cycles.
  localparam logic [TMR_W-1:0] QUAL_LD = TMR_W'(QUALIFY_CYCLES - 2);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER - 1);

  logic                 locked_s;
  pll_seq_state_e       state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [FLT_W-1:0]     flt_q, flt_d;
  logic [CNT_W-1:0]     retry_q, retry_d;
  logic [CNT_W-1:0]     loss_q, loss_d;
  logic                 timeout_q, timeout_d;
  logic                 pll_rst_q, sys_rst_n_q, ready_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    flt_d     = '0;
    retry_d   = retry_q;
    loss_d    = loss_q;
    timeout_d = timeout_q;

    if (sw_reset_i) begin
      state_d   = ST_HOLD;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (tmr_q == '0) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a simultaneous timeout.
          if (locked_s) begin
            state_d = ST_QUALIFY;
          end else if (tmr_q == '0) begin
            state_d   = ST_HOLD;
            timeout_d = 1'b1;
            if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
          end
        end
        ST_QUALIFY: begin
          if (!locked_s)         state_d = ST_WAIT_LOCK;
          else if (tmr_q == '0)  state_d = ST_RUN;
        end
        ST_RUN: begin
          // flt_d defaults to 0, so any locked cycle clears the glitch filter.
          if (!locked_s) begin
            if (flt_q == FLT_LAST) begin
              state_d = ST_HOLD;
              if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
            end else begin
              flt_d = flt_q + FLT_W'(1);
            end
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    // Reload the shared down-counter whenever a state is (re-)entered.
    if (sw_reset_i || (state_d != state_q)) begin
      case (state_d)
        ST_HOLD:      tmr_d = HOLD_LD;
        ST_WAIT_LOCK: tmr_d = LOCK_LD;
        ST_QUALIFY:   tmr_d = QUAL_LD;
        default:      tmr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      tmr_q       <= HOLD_LD;
      flt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      timeout_q   <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      flt_q       <= flt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      timeout_q   <= timeout_d;
      // Registered from next-state so outputs change together with the state.
      pll_rst_q   <= (state_d == ST_HOLD);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign timeout_o   = timeout_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int QUAL = 8;
  localparam int LF   = 3;
  localparam int CW   = 2;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          locked = 1'b0;
  logic          sw = 1'b0;
  logic          pll_rst, sys_rst_n, ready, timeout;
  logic [CW-1:0] retry_cnt, loss_cnt;

  int checks = 0;
  int failures = 0;

  always #50 clk = ~clk;

  pll_reset_sequencer #(
    .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TMO), .QUALIFY_CYCLES(QUAL),
    .LOSS_FILTER(LF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked_i(locked), .sw_reset_i(sw),
    .pll_rst_o(pll_rst), .sys_rst_n_o(sys_rst_n), .ready_o(ready),
    .timeout_o(timeout), .retry_cnt_o(retry_cnt), .loss_cnt_o(loss_cnt)
  );

  // ---------------- behavioural reference ----------------
  // Phases named by what the outside world sees; time is counted upward.
  localparam int PH_PLL_RESET = 0, PH_AWAIT = 1, PH_STABLE = 2, PH_LIVE = 3;
  int m_phase, m_elapsed, m_streak, m_low, m_retries, m_losses;
  bit m_tmo;
  bit m_delay[2];   // raw lock samples: [0] newest, [1] is what the FSM sees

  task automatic model_reset();
    m_phase = PH_PLL_RESET; m_elapsed = 0; m_streak = 0; m_low = 0;
    m_retries = 0; m_losses = 0; m_tmo = 0;
    m_delay[0] = 0; m_delay[1] = 0;
  endtask

  task automatic model_step(input bit lk, input bit s);
    bit ls;
    ls = m_delay[1];
    m_delay[1] = m_delay[0];
    m_delay[0] = lk;
    if (s) begin
      m_phase = PH_PLL_RESET; m_elapsed = 0; m_low = 0; m_tmo = 0;
    end else begin
      case (m_phase)
        PH_PLL_RESET: begin
          m_elapsed++;
          if (m_elapsed == HOLD) begin m_phase = PH_AWAIT; m_elapsed = 0; end
        end
        PH_AWAIT: begin
          m_elapsed++;
          if (ls) begin
            m_phase = PH_STABLE; m_streak = 1;
          end else if (m_elapsed == TMO) begin
            m_phase = PH_PLL_RESET; m_elapsed = 0; m_tmo = 1;
            if (m_retries < SAT) m_retries++;
          end
        end
        PH_STABLE: begin
          if (!ls) begin
            m_phase = PH_AWAIT; m_elapsed = 0;
          end else begin
            m_streak++;
            if (m_streak == QUAL) begin m_phase = PH_LIVE; m_low = 0; end
          end
        end
        default: begin
          m_low = ls ? 0 : m_low + 1;
          if (m_low == LF) begin
            m_phase = PH_PLL_RESET; m_elapsed = 0; m_low = 0;
            if (m_losses < SAT) m_losses++;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string name, input bit e_pll, input bit e_sysn,
                               input bit e_rdy, input bit e_tmo, input int e_retry,
                               input int e_loss);
    checks++;
    if (pll_rst !== e_pll || sys_rst_n !== e_sysn || ready !== e_rdy || timeout !== e_tmo ||
        retry_cnt !== CW'(e_retry) || loss_cnt !== CW'(e_loss)) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s t=%0t got pll=%b sysn=%b rdy=%b tmo=%b retry=%0d loss=%0d expected pll=%b sysn=%b rdy=%b tmo=%b retry=%0d loss=%0d",
                 name, $time, pll_rst, sys_rst_n, ready, timeout, retry_cnt, loss_cnt,
                 e_pll, e_sysn, e_rdy, e_tmo, e_retry, e_loss);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input bit exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    check_outputs(name, m_phase == PH_PLL_RESET, m_phase == PH_LIVE, m_phase == PH_LIVE,
                  m_tmo, m_retries, m_losses);
  endtask

  // One clock: inputs already set are sampled at this edge; compare #1 after it.
  task automatic tick(input string name);
    bit lk, s;
    lk = locked; s = sw;
    @(posedge clk); #1;
    model_step(lk, s);
    check_model(name);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit lk; bit sw; int n;
    bit pll; bit sysn; bit rdy; bit tmo; int retry; int loss;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit lk, input bit s, input int n, input bit pll, input bit sysn,
                         input bit rdy, input bit tmo, input int retry, input int loss);
    vec_t v;
    v.lk = lk; v.sw = s; v.n = n; v.pll = pll; v.sysn = sysn;
    v.rdy = rdy; v.tmo = tmo; v.retry = retry; v.loss = loss;
    vecs.push_back(v);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int run_left;

    // Power-up: pll_rst 4 cycles, lock raised 5 cycles after, release 2+8 cycles later.
    add_vec(0,0, 3, 1,0,0,0,0,0);
    add_vec(0,0, 1, 0,0,0,0,0,0);
    add_vec(0,0, 5, 0,0,0,0,0,0);
    add_vec(1,0, 9, 0,0,0,0,0,0);
    add_vec(1,0, 1, 0,1,1,0,0,0);
    // Loss in RUN: 2-cycle dip ignored, 3+ cycle dip re-sequences.
    add_vec(0,0, 2, 0,1,1,0,0,0);
    add_vec(1,0, 6, 0,1,1,0,0,0);
    add_vec(0,0, 4, 0,1,1,0,0,0);
    add_vec(0,0, 1, 1,0,0,0,0,1);
    add_vec(0,0, 3, 1,0,0,0,0,1);
    add_vec(0,0, 1, 0,0,0,0,0,1);
    // Never lock: first timeout, then retry saturation at 3.
    add_vec(0,0,19, 0,0,0,0,0,1);
    add_vec(0,0, 1, 1,0,0,1,1,1);
    add_vec(0,0,48, 1,0,0,1,3,1);
    add_vec(0,0,24, 1,0,0,1,3,1);
    // Lock, run, then sw_reset in RUN with timeout set.
    add_vec(1,0,30, 0,1,1,1,3,1);
    add_vec(1,1, 1, 1,0,0,0,3,1);
    add_vec(1,0, 3, 1,0,0,0,3,1);
    add_vec(1,0, 1, 0,0,0,0,3,1);
    add_vec(1,0, 7, 0,0,0,0,3,1);
    add_vec(1,0, 1, 0,1,1,0,3,1);

    // Asynchronous reset values.
    #5 rst_n = 1'b0;
    #5 check_outputs("reset_values", 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #20 rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      locked = vecs[i].lk;
      sw     = vecs[i].sw;
      repeat (vecs[i].n) tick("vec_model");
      check_outputs($sformatf("vec%0d", i), vecs[i].pll, vecs[i].sysn, vecs[i].rdy,
                    vecs[i].tmo, vecs[i].retry, vecs[i].loss);
    end

    // Qualify glitch: 1-cycle drop mid-QUALIFY, release 8 synced cycles after resume.
    sw = 1'b1; locked = 1'b0; tick("glitch_sw");
    sw = 1'b0; repeat (4) tick("glitch_hold");
    check_bit("glitch_pll_released", pll_rst, 1'b0);
    locked = 1'b1; repeat (7) tick("glitch_qual");
    locked = 1'b0; tick("glitch_drop");
    locked = 1'b1; repeat (9) tick("glitch_requal");
    check_bit("glitch_not_ready_yet", ready, 1'b0);
    tick("glitch_release");
    check_outputs("glitch_release", 0, 1, 1, 0, 3, 1);

    // rst_n mid-QUALIFY: asynchronous return to reset values, full restart.
    sw = 1'b1; tick("mid_sw");
    sw = 1'b0; repeat (7) tick("mid_to_qual");
    #10 rst_n = 1'b0;
    #1 check_outputs("mid_qual_async_reset", 1, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #20 rst_n = 1'b1;
    repeat (3) tick("restart_hold");
    check_bit("restart_pll_high", pll_rst, 1'b1);
    tick("restart_hold_end");
    check_bit("restart_pll_low", pll_rst, 1'b0);
    repeat (7) tick("restart_qual");
    check_bit("restart_not_ready", ready, 1'b0);
    tick("restart_release");
    check_bit("restart_ready", ready, 1'b1);

    // Randomized lock behaviour and occasional sw strobes against the reference.
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        locked = ~locked;
        if (locked) run_left = $urandom_range(1, 30);
        else run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 4);
      end
      run_left--;
      sw = ($urandom_range(0, 199) == 0);
      tick("random");
    end
    sw = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
